// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and width helpers for the FIFO read-side packer.
// Timeout flushing of partial words is enabled with FIFO_RD_PACKER_TIMEOUT_EN.
package fifo_rd_packer_pkg;

    localparam int DSIZE_DEF   = 8;
    localparam int RATIO_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    function automatic int cnt_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic int idle_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter; raises o_expired once TIMEOUT idle cycles elapse.
// Used by fifo_rd_packer only when FIFO_RD_PACKER_TIMEOUT_EN is defined.
module fifo_rd_idle_timer
    import fifo_rd_packer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_clear,
    output logic o_expired
);

    localparam int TW = idle_width(TIMEOUT);

    logic [TW-1:0] r_cnt;
    logic          w_sat;

    assign w_sat     = (r_cnt == TW'(TIMEOUT));
    assign o_expired = w_sat;

    // Holds at TIMEOUT while the flush waits for the output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_idle && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs RATIO first-word-fall-through FIFO entries into one valid/ready word.
// Define FIFO_RD_PACKER_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int RATIO   = RATIO_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int CW = cnt_width(RATIO);

    logic [CW-1:0]                r_cnt;
    logic [RATIO-2:0][DSIZE-1:0]  r_acc;
    logic [DSIZE*RATIO-1:0]       r_data;
    logic [RATIO-1:0]             r_keep;
    logic                         r_valid;

    logic w_out_free;
    logic w_last;
    logic w_pop;

    if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_cfg
    end

    assign w_out_free = !r_valid || m_ready;
    assign w_last     = (r_cnt == CW'(RATIO - 1));
    assign w_pop      = !rrst && !rempty && (!w_last || w_out_free);

    assign rinc    = w_pop;
    assign m_data  = r_data;
    assign m_keep  = r_keep;
    assign m_valid = r_valid;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic                   w_expired;
    logic                   w_flush;
    logic [DSIZE*RATIO-1:0] w_flush_data;
    logic [RATIO-1:0]       w_flush_keep;

    fifo_rd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk     (rclk),
        .i_rst     (rrst),
        .i_idle    ((r_cnt != '0) && rempty),
        .i_clear   (w_pop || w_flush),
        .o_expired (w_expired)
    );

    // A pop in the flush-pending cycle wins; the partial word keeps growing
    assign w_flush = w_expired && w_out_free && !w_pop;

    always_comb begin
        w_flush_data = '0;
        w_flush_keep = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(r_cnt)) begin
                w_flush_data[i*DSIZE +: DSIZE] = r_acc[i];
                w_flush_keep[i]                = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
            if (w_pop) begin
                if (w_last) begin
                    r_data  <= {rdata, r_acc};
                    r_keep  <= '1;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_acc[i] <= rdata;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
            end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            if (w_flush) begin
                r_data  <= w_flush_data;
                r_keep  <= w_flush_keep;
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a queue-backed FWFT FIFO model.
// Timeout expectations follow FIFO_RD_PACKER_TIMEOUT_EN.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic        rempty = 1'b1;
    logic        rinc;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    logic [7:0] fq[$];
    exp_t       eq[$];
    int         xfer_cyc[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run = 0;
    int max_run = 0;
    bit gap_en = 0;
    bit gap_ph = 0;
    bit pop_pend = 0;
    bit hold_prev = 0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE   (8),
        .RATIO   (4),
        .TIMEOUT (16)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        rempty = (fq.size() == 0) || (gap_en && gap_ph);
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        refresh();
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        eq.push_back(e);
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge rclk);
            if (fq.size() == 0 && eq.size() == 0 && !m_valid) return;
        end
        errors++;
        checks++;
        $display("FAIL %s: timeout fifo=%0d pending=%0d valid=%b expected idle",
                 name, fq.size(), eq.size(), m_valid);
    endtask

    // FIFO model: pop decided at the previous falling edge
    always @(posedge rclk) begin
        cyc++;
        if (pop_pend && fq.size() != 0) void'(fq.pop_front());
        gap_ph = ~gap_ph;
        #1;
        refresh();
    end

    // Monitor: pops, transfers and hold stability
    always @(negedge rclk) begin
        pop_pend = rinc;
        if (rinc) begin
            chk("pop_while_empty", {31'd0, rempty}, 32'd0);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (hold_prev && m_valid) begin
            chk("hold_data", m_data, prev_data);
            chk("hold_keep", {28'd0, m_keep}, {28'd0, prev_keep});
        end
        hold_prev = m_valid && !m_ready;
        prev_data = m_data;
        prev_keep = m_keep;
        if (m_valid && m_ready) begin
            xfer_cyc.push_back(cyc);
            if (eq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_word: got %h keep %h expected none",
                         m_data, m_keep);
            end else begin
                exp_t e;
                e = eq.pop_front();
                chk("word_data", m_data, e.d);
                chk("word_keep", {28'd0, m_keep}, {28'd0, e.k});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset and streaming
        for (int i = 1; i <= 8; i++) push(8'(i));
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        repeat (3) @(negedge rclk);
        chk("rst_rinc", {31'd0, rinc}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_keep", {28'd0, m_keep}, 32'd0);
        @(posedge rclk);
        #2;
        max_run = 0;
        xfer_cyc.delete();
        rrst = 1'b0;
        m_ready = 1'b1;
        wait_idle(100, "stream_drain");
        chk("stream_rinc_run", max_run, 32'd8);
        chk("stream_xfers", xfer_cyc.size(), 32'd2);
        if (xfer_cyc.size() == 2)
            chk("stream_spacing", xfer_cyc[1] - xfer_cyc[0], 32'd4);

        // Back-to-back words across boundaries
        @(posedge rclk);
        #2;
        xfer_cyc.delete();
        for (int i = 0; i < 12; i++) push(8'h41 + 8'(i));
        expect_word(32'h44434241, 4'hF);
        expect_word(32'h48474645, 4'hF);
        expect_word(32'h4C4B4A49, 4'hF);
        wait_idle(100, "b2b_drain");
        chk("b2b_xfers", xfer_cyc.size(), 32'd3);
        if (xfer_cyc.size() == 3) begin
            chk("b2b_spacing0", xfer_cyc[1] - xfer_cyc[0], 32'd4);
            chk("b2b_spacing1", xfer_cyc[2] - xfer_cyc[1], 32'd4);
        end

        // Backpressure
        @(posedge rclk);
        #2;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        expect_word(32'h14131211, 4'hF);
        expect_word(32'h18171615, 4'hF);
        repeat (20) @(negedge rclk);
        chk("bp_fifo_left", fq.size(), 32'd1);
        chk("bp_rinc_stall", {31'd0, rinc}, 32'd0);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_data", m_data, 32'h14131211);
        @(posedge rclk);
        #2;
        m_ready = 1'b1;
        wait_idle(100, "bp_drain");

        // Empty gaps
        @(posedge rclk);
        #2;
        gap_en = 1'b1;
        refresh();
        for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
        expect_word(32'h24232221, 4'hF);
        expect_word(32'h28272625, 4'hF);
        wait_idle(200, "gap_drain");
        gap_en = 1'b0;
        refresh();

        // Mid-word reset
        @(posedge rclk);
        #2;
        push(8'h3A);
        push(8'h3B);
        repeat (4) @(posedge rclk);
        #2;
        rrst = 1'b1;
        @(negedge rclk);
        chk("midrst_rinc", {31'd0, rinc}, 32'd0);
        @(posedge rclk);
        #2;
        rrst = 1'b0;
        @(negedge rclk);
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_keep", {28'd0, m_keep}, 32'd0);
        @(posedge rclk);
        #2;
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        expect_word(32'h34333231, 4'hF);
        wait_idle(100, "midrst_drain");

        // Partial word timeout
        @(posedge rclk);
        #2;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        expect_word(32'h00A3A2A1, 4'h7);
        wait_idle(100, "timeout_flush");
`else
        repeat (40) @(negedge rclk);
        chk("no_timeout_valid", {31'd0, m_valid}, 32'd0);
        @(posedge rclk);
        #2;
        push(8'hA4);
        expect_word(32'hA4A3A2A1, 4'hF);
        wait_idle(100, "no_timeout_complete");
`endif

        repeat (4) @(negedge rclk);
        chk("final_pending", eq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
